// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-facing bundle of uart_tx_arbiter: request side, transmitter side and status.
// The slave modport is the arbiter's view; master is the environment (producers + transmitter).
interface uart_tx_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDW   = 3
);
  logic [NREQ-1:0]       req;
  logic [NREQ*NBITS-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic [NBITS-1:0]      tx_din;
  logic                  tx_start;
  logic                  tx_done;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic                  timeout_err;

  modport master (
    output req, req_data, tx_done,
    input  ack, tx_din, tx_start, busy, grant_id, timeout_err
  );

  modport slave (
    input  req, req_data, tx_done,
    output ack, tx_din, tx_start, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers, with a WAIT watchdog.
// Optional macro UART_ARB_TAG_EN: every grant sends a tag frame {4'hA, pad, id} before the payload.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int NBITS   = 8,
  parameter int TIMEOUT = 4096,
  parameter int IDW     = 3
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NBITS-1:0] tx_din_q, tx_din_d;
  logic             tx_start_q, tx_start_d;
  logic             busy_q, busy_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             timeout_err_q, timeout_err_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
`ifdef UART_ARB_TAG_EN
  logic             tag_q, tag_d;
  logic [NBITS-1:0] data_q, data_d;
`endif

  logic             hit_s, hit_hi_s, above_s;
  logic [IDW-1:0]   win_s, win_hi_s, win_lo_s, next_ptr_s;
  logic [NBITS-1:0] win_data_s;

  // Winner: lowest set req at or above rr_ptr, else lowest set req overall (wrap).
  always_comb begin
    hit_s    = |bus.req;
    hit_hi_s = 1'b0;
    above_s  = 1'b0;
    win_hi_s = {IDW{1'b0}};
    win_lo_s = {IDW{1'b0}};
    for (int c = NREQ - 1; c >= 0; c--) begin
      above_s  = bus.req[c] && (IDW'(c) >= rr_ptr_q);
      win_hi_s = above_s ? IDW'(c) : win_hi_s;
      hit_hi_s = hit_hi_s | above_s;
      win_lo_s = bus.req[c] ? IDW'(c) : win_lo_s;
    end
    win_s      = hit_hi_s ? win_hi_s : win_lo_s;
    win_data_s = {NBITS{1'b0}};
    for (int c = 0; c < NREQ; c++) begin
      win_data_s = (IDW'(c) == win_s) ? bus.req_data[c*NBITS +: NBITS] : win_data_s;
    end
    next_ptr_s = (grant_id_q == IDW'(NREQ - 1)) ? {IDW{1'b0}} : grant_id_q + IDW'(1'b1);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    ack_d         = {NREQ{1'b0}};
    tx_din_d      = tx_din_q;
    tx_start_d    = 1'b0;
    grant_id_d    = grant_id_q;
    timeout_err_d = 1'b0;
    wdog_d        = wdog_q;
`ifdef UART_ARB_TAG_EN
    tag_d         = tag_q;
    data_d        = data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          state_d    = ST_LAUNCH;
          grant_id_d = win_s;
          ack_d      = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
`ifdef UART_ARB_TAG_EN
          tag_d      = 1'b1;
          data_d     = win_data_s;
          tx_din_d   = {4'hA, {(NBITS-4-IDW){1'b0}}, win_s};
`else
          tx_din_d   = win_data_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        tx_start_d = 1'b1;
        wdog_d     = {WDW{1'b0}};
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + WDW'(1'b1);
        if (bus.tx_done) begin
          state_d = ST_RELEASE;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          // Abort drops any pending payload frame and moves fairness past the winner.
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr_s;
          state_d       = ST_IDLE;
`ifdef UART_ARB_TAG_EN
          tag_d         = 1'b0;
`endif
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RELEASE: begin
        if (bus.tx_done) begin
          state_d = ST_RELEASE;
        end else begin
`ifdef UART_ARB_TAG_EN
          if (tag_q) begin
            tag_d    = 1'b0;
            tx_din_d = data_q;
            state_d  = ST_LAUNCH;
          end else begin
            rr_ptr_d = next_ptr_s;
            state_d  = ST_IDLE;
          end
`else
          rr_ptr_d = next_ptr_s;
          state_d  = ST_IDLE;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= {IDW{1'b0}};
      ack_q         <= {NREQ{1'b0}};
      tx_din_q      <= {NBITS{1'b0}};
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      grant_id_q    <= {IDW{1'b0}};
      timeout_err_q <= 1'b0;
      wdog_q        <= {WDW{1'b0}};
`ifdef UART_ARB_TAG_EN
      tag_q         <= 1'b0;
      data_q        <= {NBITS{1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      ack_q         <= ack_d;
      tx_din_q      <= tx_din_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      grant_id_q    <= grant_id_d;
      timeout_err_q <= timeout_err_d;
      wdog_q        <= wdog_d;
`ifdef UART_ARB_TAG_EN
      tag_q         <= tag_d;
      data_q        <= data_d;
`endif
    end
  end

  assign bus.ack         = ack_q;
  assign bus.tx_din      = tx_din_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grants and frame bytes are checked against a scoreboard.
// Works with or without UART_ARB_TAG_EN; tagged builds expect a tag frame before each payload.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int NBITS   = 8;
  localparam int IDW     = 3;
  localparam int TIMEOUT = 16;
`ifdef UART_ARB_TAG_EN
  localparam int FPG = 2;
`else
  localparam int FPG = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .NBITS(NBITS), .IDW(IDW)) bus ();

  uart_tx_arbiter #(
    .NREQ(NREQ), .NBITS(NBITS), .TIMEOUT(TIMEOUT), .IDW(IDW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         nack        = 0;
  int         nstart      = 0;
  bit         done_en     = 1'b1;
  int         done_delay  = 8;
  int         done_len    = 5;
  logic [7:0] dbyte [NREQ];
  int         grant_exp [$];
  logic [7:0] tx_exp [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id);
    grant_exp.push_back(id);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.busy !== 1'b0 && cyc < 300);
    check("idle_reached", {31'd0, bus.busy}, 32'd0);
  endtask

  // Hold req until n acks are seen, then drop it and let the last frame finish.
  task automatic hold_req(input logic [3:0] r, input int n);
    int got = 0;
    int cyc = 0;
    bus.req = r;
    while (got < n && cyc < 60 * n) begin
      @(negedge clk);
      cyc++;
      if (|bus.ack) got++;
    end
    bus.req = 4'b0000;
    check("hold_acks", got, n);
    wait_idle();
  endtask

  // Transmitter model: raises tx_done done_delay cycles after tx_start, for done_len cycles.
  initial begin : xmtr
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1 && done_en) begin
        repeat (done_delay) @(negedge clk);
        bus.tx_done = 1'b1;
        repeat (done_len) @(negedge clk);
        bus.tx_done = 1'b0;
      end
    end
  end

  // Scoreboard: each ack pops an expected grant; each tx_start pops an expected frame byte.
  initial begin : monitor
    int id;
    forever begin
      @(negedge clk);
      if (bus.timeout_err === 1'b1) tx_exp.delete();
      if (|bus.ack) begin
        nack++;
        if (grant_exp.size() == 0) begin
          check("sb_unexpected_ack", {28'd0, bus.ack}, 32'd0);
        end else begin
          id = grant_exp.pop_front();
          check("sb_ack", {28'd0, bus.ack}, 32'd1 << id);
          check("sb_grant_id", {29'd0, bus.grant_id}, id);
`ifdef UART_ARB_TAG_EN
          tx_exp.push_back({4'hA, 1'b0, id[2:0]});
`endif
          tx_exp.push_back(dbyte[id]);
        end
      end
      if (bus.tx_start === 1'b1) begin
        nstart++;
        if (tx_exp.size() == 0) check("sb_unexpected_start", {31'd0, bus.tx_start}, 32'd0);
        else check("sb_tx_din", {24'd0, bus.tx_din}, {24'd0, tx_exp.pop_front()});
      end
    end
  end

  initial begin : stim
    int cyc, n0, s0;
    dbyte[0] = 8'hC0;
    dbyte[1] = 8'h33;
    dbyte[2] = 8'h5A;
    dbyte[3] = 8'hD3;
    bus.req_data = {dbyte[3], dbyte[2], dbyte[1], dbyte[0]};
    bus.req      = 4'b1111;
    reset        = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ack", {28'd0, bus.ack}, 32'd0);
      check("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_grant_id", {29'd0, bus.grant_id}, 32'd0);
      check("rst_tx_din", {24'd0, bus.tx_din}, 32'd0);
    end
    push_exp(0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_first_ack", {28'd0, bus.ack}, 32'd1);
    bus.req = 4'b0000;
    wait_idle();

    // Single request latency; other reqs raised mid-frame must be ignored.
    done_len = 5;
    n0 = nack;
    s0 = nstart;
    push_exp(2);
    bus.req = 4'b0100;
    @(negedge clk);
    check("lat_ack", {28'd0, bus.ack}, 32'h4);
    check("lat_busy", {31'd0, bus.busy}, 32'd1);
    bus.req = 4'b0000;
    @(negedge clk);
    check("lat_tx_start", {31'd0, bus.tx_start}, 32'd1);
    check("lat_tx_din", {24'd0, bus.tx_din}, (FPG == 2) ? 32'hA2 : 32'h5A);
    bus.req = 4'b1011;
    repeat (3) @(negedge clk);
    bus.req = 4'b0000;
    wait_idle();
    check("single_acks", nack - n0, 1);
    check("single_starts", nstart - s0, FPG);

    // Skip and wrap, then full round-robin from pointer 0.
    done_len = 9;
    push_exp(3);
    hold_req(4'b1000, 1);
    push_exp(0); push_exp(2);
    hold_req(4'b0101, 2);
    push_exp(0); push_exp(0); push_exp(0);
    hold_req(4'b0001, 3);
    push_exp(3);
    hold_req(4'b1000, 1);
    n0 = nack;
    s0 = nstart;
    for (int i = 0; i < 8; i++) push_exp(i % NREQ);
    hold_req(4'b1111, 8);
    check("rr_acks", nack - n0, 8);
    check("rr_starts", nstart - s0, 8 * FPG);

    // Watchdog: transmitter never answers requester 0, requester 1 is served next.
    done_en = 1'b0;
    push_exp(0); push_exp(1);
    bus.req = 4'b0011;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(|bus.ack) && cyc < 20);
    check("to_first_ack", {28'd0, bus.ack}, 32'd1);
    bus.req = 4'b0010;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (bus.tx_start !== 1'b1 && cyc < 20);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (bus.timeout_err !== 1'b1 && cyc < 40);
    check("to_latency", cyc, TIMEOUT);
    check("to_busy", {31'd0, bus.busy}, 32'd0);
    done_en = 1'b1;
    @(negedge clk);
    check("to_pulse", {31'd0, bus.timeout_err}, 32'd0);
    check("to_next_ack", {28'd0, bus.ack}, 32'h2);
    bus.req = 4'b0000;
    wait_idle();

    // Requester 1 payload 8'h33 (tag 8'hA1 first when tagging is built in).
    n0 = nack;
    s0 = nstart;
    push_exp(1);
    hold_req(4'b0010, 1);
    check("tag_acks", nack - n0, 1);
    check("tag_starts", nstart - s0, FPG);
    check("tx_din_hold", {24'd0, bus.tx_din}, 32'h33);

    check("sb_grants_left", grant_exp.size(), 0);
    check("sb_frames_left", tx_exp.size(), 0);
    check("total_acks", nack, 20);
    check("total_starts", nstart, 20 * FPG - (FPG - 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
